alu_writeback: RTL and testbench

Execute/writeback stage directly downstream of the ALU. It accepts one ALU result per handshake and evaluates the instruction's ARM condition field against the architectural NZCV flags. Passing instructions commit their flags to the CPSR flag register and their result to a one-entry output register that drains into the register-file write port. The stage also returns the committed carry to the ALU for ADC/SBC/RSC.

---
 rtl/arm_pkg.sv | 50 +++++
 rtl/cond_check.sv | 38 +++
 rtl/alu_writeback.sv | 106 ++++++++++
 tb/tb_alu_writeback.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM definitions: condition-field encodings, NZCV bit positions and
// data-processing opcodes used by decode, ALU and writeback.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int unsigned N_BIT = 3;
    localparam int unsigned Z_BIT = 2;
    localparam int unsigned C_BIT = 1;
    localparam int unsigned V_BIT = 0;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluation against an NZCV flag set.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = nzcv[N_BIT];
        z = nzcv[Z_BIT];
        c = nzcv[C_BIT];
        v = nzcv[V_BIT];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// Execute/writeback stage: conditional flag commit, one-entry register-file
// write buffer, carry feedback to the ALU and a saturating annul counter.
module alu_writeback
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_nzcv,
    input  logic              result_writeback,
    input  logic              nzcv_writeback,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        cond,
    input  logic              flush,
    output logic              rf_we,
    input  logic              rf_ready,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_write,
    output logic [3:0]        cpsr_nzcv,
    output logic              carry_out,
    output logic [15:0]       annul_count
);

    logic [3:0]        cpsr_q, cpsr_d;
    logic              we_q, we_d;
    logic              pc_q, pc_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       annul_q, annul_d;

    logic cond_pass;
    logic accept;

    cond_check u_cond_check (
        .cond (cond),
        .nzcv (cpsr_q),
        .pass (cond_pass)
    );

    assign in_ready = ~we_q | rf_ready;
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        cpsr_d  = cpsr_q;
        we_d    = we_q;
        pc_d    = pc_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        annul_d = annul_q;

        // Drain first; a same-cycle load below overrides it for back-to-back writes.
        if (we_q && rf_ready) begin
            we_d = 1'b0;
            pc_d = 1'b0;
        end

        if (accept) begin
            if (cond_pass) begin
                if (nzcv_writeback) begin
                    cpsr_d = alu_nzcv;
                end
                if (result_writeback) begin
                    we_d    = 1'b1;
                    pc_d    = (REG_AW'(PC_REG) == rd);
                    waddr_d = rd;
                    wdata_d = alu_result;
                end
            end else if (annul_q != '1) begin
                annul_d = annul_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpsr_q  <= '0;
            we_q    <= 1'b0;
            pc_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            annul_q <= '0;
        end else begin
            cpsr_q  <= cpsr_d;
            we_q    <= we_d;
            pc_q    <= pc_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            annul_q <= annul_d;
        end
    end

    assign rf_we       = we_q;
    assign pc_write    = pc_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign cpsr_nzcv   = cpsr_q;
    assign carry_out   = cpsr_q[C_BIT];
    assign annul_count = annul_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed test of alu_writeback: flags, conditions, stalls, flush, PC write,
// reset mid-operation and annul counter saturation.
module tb_alu_writeback;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic        result_writeback;
    logic        nzcv_writeback;
    logic [3:0]  rd;
    logic [3:0]  cond;
    logic        flush;
    logic        rf_we;
    logic        rf_ready;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_write;
    logic [3:0]  cpsr_nzcv;
    logic        carry_out;
    logic [15:0] annul_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu_writeback #(
        .DATA_W (32),
        .REG_AW (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .alu_result       (alu_result),
        .alu_nzcv         (alu_nzcv),
        .result_writeback (result_writeback),
        .nzcv_writeback   (nzcv_writeback),
        .rd               (rd),
        .cond             (cond),
        .flush            (flush),
        .rf_we            (rf_we),
        .rf_ready         (rf_ready),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .pc_write         (pc_write),
        .cpsr_nzcv        (cpsr_nzcv),
        .carry_out        (carry_out),
        .annul_count      (annul_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] c, input logic [3:0] f, input logic [31:0] res,
                        input logic [3:0] r, input logic rwb, input logic fwb);
        in_valid         = 1'b1;
        cond             = c;
        alu_nzcv         = f;
        alu_result       = res;
        rd               = r;
        result_writeback = rwb;
        nzcv_writeback   = fwb;
    endtask

    task automatic wb_state(input string tag, input logic we, input logic [3:0] a,
                            input logic [31:0] d);
        check({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(a));
            check({tag, ".rf_wdata"}, rf_wdata, d);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_result = '0; alu_nzcv = '0;
        result_writeback = 1'b0; nzcv_writeback = 1'b0; rd = '0; cond = 4'hE;
        flush = 1'b0; rf_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst.rf_we", 32'(rf_we), 0);
        check("rst.pc_write", 32'(pc_write), 0);
        check("rst.rf_waddr", 32'(rf_waddr), 0);
        check("rst.rf_wdata", rf_wdata, 0);
        check("rst.cpsr", 32'(cpsr_nzcv), 0);
        check("rst.annul", 32'(annul_count), 0);
        check("rst.in_ready", 32'(in_ready), 1);

        // ADDS r2 = 0, flags 0110
        beat(4'hE, 4'b0110, 32'd0, 4'd2, 1'b1, 1'b1);
        tick();
        wb_state("adds", 1'b1, 4'd2, 32'd0);
        check("adds.cpsr", 32'(cpsr_nzcv), 32'h6);
        check("adds.carry", 32'(carry_out), 1);

        // CMP -> Z=1 only
        beat(4'hE, 4'b0100, 32'd0, 4'd0, 1'b0, 1'b1);
        tick();
        check("cmp.cpsr", 32'(cpsr_nzcv), 32'h4);
        check("cmp.carry", 32'(carry_out), 0);
        check("cmp.rf_we", 32'(rf_we), 0);

        // MOVEQ r3 = 5 (passes)
        beat(4'h0, 4'b0000, 32'd5, 4'd3, 1'b1, 1'b0);
        tick();
        wb_state("moveq", 1'b1, 4'd3, 32'd5);

        // MOVNE r4 = 7 (annulled)
        beat(4'h1, 4'b0000, 32'd7, 4'd4, 1'b1, 1'b0);
        tick();
        check("movne.rf_we", 32'(rf_we), 0);
        check("movne.annul", 32'(annul_count), 1);
        check("movne.cpsr", 32'(cpsr_nzcv), 32'h4);

        // Stall: entry r5 pending, rf_ready low, next beat r6 held upstream
        beat(4'hE, 4'b0000, 32'h55, 4'd5, 1'b1, 1'b0);
        tick();
        wb_state("stall.load", 1'b1, 4'd5, 32'h55);
        rf_ready = 1'b0;
        beat(4'hE, 4'b0000, 32'h66, 4'd6, 1'b1, 1'b0);
        #1;
        check("stall.in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_state("stall.hold", 1'b1, 4'd5, 32'h55);
            check("stall.in_ready_hold", 32'(in_ready), 0);
        end
        rf_ready = 1'b1;
        #1;
        check("stall.release_ready", 32'(in_ready), 1);
        tick();
        wb_state("stall.b2b", 1'b1, 4'd6, 32'h66);

        // NV: annulled, flags unchanged
        beat(4'hF, 4'b1111, 32'h77, 4'd7, 1'b1, 1'b1);
        tick();
        check("nv.rf_we", 32'(rf_we), 0);
        check("nv.cpsr", 32'(cpsr_nzcv), 32'h4);
        check("nv.annul", 32'(annul_count), 2);

        // Flush: passing beat dropped, failing beat not counted
        beat(4'hE, 4'b1111, 32'h88, 4'd8, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        check("flush.rf_we", 32'(rf_we), 0);
        check("flush.cpsr", 32'(cpsr_nzcv), 32'h4);
        beat(4'h1, 4'b0000, 32'h88, 4'd8, 1'b1, 1'b0);
        tick();
        check("flush.annul", 32'(annul_count), 2);
        flush = 1'b0;

        // Flush during stall leaves the committed entry intact
        beat(4'hE, 4'b0000, 32'h99, 4'd9, 1'b1, 1'b0);
        tick();
        rf_ready = 1'b0;
        flush = 1'b1;
        beat(4'hE, 4'b0000, 32'hAA, 4'd10, 1'b1, 1'b0);
        tick();
        wb_state("flushstall", 1'b1, 4'd9, 32'h99);
        flush = 1'b0; rf_ready = 1'b1; in_valid = 1'b0;
        tick();
        check("flushstall.drain", 32'(rf_we), 0);

        // PC write
        beat(4'hE, 4'b0000, 32'h0000_0100, 4'd15, 1'b1, 1'b0);
        tick();
        wb_state("pc", 1'b1, 4'd15, 32'h100);
        check("pc.pc_write", 32'(pc_write), 1);
        beat(4'hE, 4'b0000, 32'h11, 4'd1, 1'b1, 1'b0);
        tick();
        check("pc.pc_write_r1", 32'(pc_write), 0);
        in_valid = 1'b0;
        tick();
        check("pc.idle_we", 32'(rf_we), 0);

        // Flags N=1,V=1 then GE pass, LT fail, GT pass, LS pass, HI fail
        beat(4'hE, 4'b1001, 32'd0, 4'd0, 1'b0, 1'b1);
        tick();
        check("nv11.cpsr", 32'(cpsr_nzcv), 32'h9);
        beat(4'hA, 4'b0000, 32'd1, 4'd1, 1'b1, 1'b0);
        tick();
        wb_state("ge", 1'b1, 4'd1, 32'd1);
        beat(4'hB, 4'b0000, 32'd2, 4'd2, 1'b1, 1'b0);
        tick();
        check("lt.rf_we", 32'(rf_we), 0);
        beat(4'hC, 4'b0000, 32'd3, 4'd3, 1'b1, 1'b0);
        tick();
        wb_state("gt", 1'b1, 4'd3, 32'd3);
        beat(4'h9, 4'b0000, 32'd4, 4'd4, 1'b1, 1'b0);
        tick();
        wb_state("ls", 1'b1, 4'd4, 32'd4);
        beat(4'h8, 4'b0000, 32'd5, 4'd5, 1'b1, 1'b0);
        tick();
        check("hi.rf_we", 32'(rf_we), 0);
        check("cond.annul", 32'(annul_count), 4);

        // Reset with a pending write and set flags
        beat(4'hE, 4'b1111, 32'hDEAD, 4'd1, 1'b1, 1'b1);
        tick();
        wb_state("prereset", 1'b1, 4'd1, 32'hDEAD);
        check("prereset.cpsr", 32'(cpsr_nzcv), 32'hF);
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst.rf_we", 32'(rf_we), 0);
        check("midrst.cpsr", 32'(cpsr_nzcv), 0);
        check("midrst.annul", 32'(annul_count), 0);

        // Saturation: continuous NV beats
        beat(4'hF, 4'b1111, 32'd0, 4'd1, 1'b1, 1'b1);
        repeat (65534) tick();
        check("sat.fffe", 32'(annul_count), 32'hFFFE);
        tick();
        check("sat.ffff", 32'(annul_count), 32'hFFFF);
        repeat (3) tick();
        check("sat.hold", 32'(annul_count), 32'hFFFF);
        check("sat.rf_we", 32'(rf_we), 0);
        check("sat.cpsr", 32'(cpsr_nzcv), 0);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
